// File: rtl/y86_memory_stage_if.sv
// Data-memory request/acknowledge bus between the Y86 memory stage (master)
// and the data memory (slave).
interface y86_memory_stage_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/y86_memory_stage.sv
// Y86 memory stage: one instruction at a time, at most one data access, then a
// result for writeback. Define MEM_TIMEOUT_EN to abort unacknowledged accesses.
module y86_memory_stage #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valC,
    input  logic [DATA_W-1:0] valP,
    input  logic              Cnd,
    y86_memory_stage_if.master mem,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [DATA_W-1:0] out_valE,
    output logic [DATA_W-1:0] out_valM,
    output logic [DATA_W-1:0] new_pc,
    output logic [1:0]        stat
);

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_RMMOVL = 4'h4;
    localparam logic [3:0] ICODE_MRMOVL = 4'h5;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHL  = 4'hA;
    localparam logic [3:0] ICODE_POPL   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_INS = 2'd2;
    localparam logic [1:0] STAT_ADR = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        STOP
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]        r_icode;
    logic [DATA_W-1:0] r_valE;
    logic [DATA_W-1:0] r_valA;
    logic [DATA_W-1:0] r_valC;
    logic [DATA_W-1:0] r_valP;
    logic              r_cnd;
    logic [DATA_W-1:0] r_valM;
    logic [1:0]        r_stat;

    logic       accept;
    logic       ack_take;
    logic       tmo_take;
    logic [1:0] stat_in;
    logic       timeout_hit;
    logic [CNT_W-1:0] tmo_count;

    function automatic logic is_mem_op(input logic [3:0] ic);
        return ic inside {ICODE_RMMOVL, ICODE_MRMOVL, ICODE_CALL,
                          ICODE_RET, ICODE_PUSHL, ICODE_POPL};
    endfunction

    function automatic logic is_write_op(input logic [3:0] ic);
        return ic inside {ICODE_RMMOVL, ICODE_CALL, ICODE_PUSHL};
    endfunction

    always_comb begin
        stat_in = STAT_AOK;
        if (icode == ICODE_HALT) begin
            stat_in = STAT_HLT;
        end else if (icode > ICODE_POPL) begin
            stat_in = STAT_INS;
        end
    end

    // The counter only exists when the timeout feature is built in; otherwise
    // it is a constant zero and timeout_hit can never fire.
`ifdef MEM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_count <= '0;
        end else if (state == REQ && !mem.mem_ack) begin
            tmo_count <= tmo_count + CNT_W'(1);
        end else begin
            tmo_count <= '0;
        end
    end
`else
    localparam bit TMO_EN = 1'b0;

    assign tmo_count = '0;
`endif

    assign timeout_hit = TMO_EN && (tmo_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack is checked before the timeout so a late ack on the terminal count wins.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack_take   = 1'b0;
        tmo_take   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = is_mem_op(icode) ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    ack_take   = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    tmo_take   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = (r_stat == STAT_AOK) ? IDLE : STOP;
                end
            end
            STOP: begin
                state_next = STOP;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_icode <= '0;
            r_valE  <= '0;
            r_valA  <= '0;
            r_valC  <= '0;
            r_valP  <= '0;
            r_cnd   <= 1'b0;
            r_valM  <= '0;
            r_stat  <= STAT_AOK;
        end else if (accept) begin
            r_icode <= icode;
            r_valE  <= valE;
            r_valA  <= valA;
            r_valC  <= valC;
            r_valP  <= valP;
            r_cnd   <= Cnd;
            r_valM  <= '0;
            r_stat  <= stat_in;
        end else if (ack_take) begin
            if (!is_write_op(r_icode)) begin
                r_valM <= mem.mem_rdata;
            end
        end else if (tmo_take) begin
            r_valM <= '0;
            r_stat <= STAT_ADR;
        end
    end

    // Bus outputs are driven only while a request is outstanding.
    always_comb begin
        mem.mem_req   = (state == REQ);
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (state == REQ) begin
            mem.mem_we   = is_write_op(r_icode);
            mem.mem_addr = (r_icode == ICODE_RET || r_icode == ICODE_POPL) ? r_valA : r_valE;
            if (is_write_op(r_icode)) begin
                mem.mem_wdata = (r_icode == ICODE_CALL) ? r_valP : r_valA;
            end
        end
    end

    always_comb begin
        case (r_icode)
            ICODE_CALL: new_pc = r_valC;
            ICODE_JXX:  new_pc = r_cnd ? r_valC : r_valP;
            ICODE_RET:  new_pc = r_valM;
            default:    new_pc = r_valP;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_icode = r_icode;
    assign out_valE  = r_valE;
    assign out_valM  = r_valM;
    assign stat      = r_stat;

endmodule

// File: tb/tb_y86_memory_stage.sv
// Scoreboard bench for y86_memory_stage with a configurable-latency memory
// responder; timeout cases run only when MEM_TIMEOUT_EN is defined.
module tb_y86_memory_stage;

    localparam int TB_TIMEOUT = 4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [31:0] valE;
    logic [31:0] valA;
    logic [31:0] valC;
    logic [31:0] valP;
    logic        Cnd;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [31:0] out_valE;
    logic [31:0] out_valM;
    logic [31:0] new_pc;
    logic [1:0]  stat;

    y86_memory_stage_if #(.DATA_W(32)) bus ();

    y86_memory_stage #(
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .valE      (valE),
        .valA      (valA),
        .valC      (valC),
        .valP      (valP),
        .Cnd       (Cnd),
        .mem       (bus.master),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_icode (out_icode),
        .out_valE  (out_valE),
        .out_valM  (out_valM),
        .new_pc    (new_pc),
        .stat      (stat)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [31:0] valE;
        logic [31:0] valM;
        logic [31:0] pc;
        logic [1:0]  stat;
        int          lat;
        int          acc;
    } out_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    out_exp_t out_q[$];
    mem_exp_t mem_q[$];

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          ack_delay    = 0;
    int          wait_cnt     = 0;
    int          req_len      = 0;
    int          last_req_len = 0;
    logic [31:0] rdata_val    = 32'h0;
    bit          head_seen    = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after ack_delay request cycles (never if negative).
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hBAD0_0000;
        forever begin
            @(negedge clock);
            if (reset) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
                req_len     = 0;
            end else if (bus.mem_req && !bus.mem_ack) begin
                req_len++;
                if (mem_q.size() == 0) begin
                    checkOutput("unexpected_req", 32'(bus.mem_req), 32'h0);
                end else begin
                    checkOutput("mem_we", 32'(bus.mem_we), 32'(mem_q[0].we));
                    checkOutput("mem_addr", bus.mem_addr, mem_q[0].addr);
                    if (mem_q[0].we) begin
                        checkOutput("mem_wdata", bus.mem_wdata, mem_q[0].wdata);
                    end
                    if (ack_delay >= 0 && wait_cnt >= ack_delay) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = rdata_val;
                        wait_cnt      = 0;
                        void'(mem_q.pop_front());
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                if (!bus.mem_req && req_len != 0) begin
                    last_req_len = req_len;
                    req_len      = 0;
                end
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hBAD0_0000;
                wait_cnt      = 0;
            end
        end
    end

    // Output monitor: every cycle out_valid is high must match the queue head.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && out_valid) begin
                if (out_q.size() == 0) begin
                    checkOutput("unexpected_valid", 32'(out_valid), 32'h0);
                end else begin
                    if (!head_seen) begin
                        checkOutput("latency", cyc - out_q[0].acc + 1, out_q[0].lat);
                        head_seen = 1'b1;
                    end
                    checkOutput("out_icode", 32'(out_icode), 32'(out_q[0].icode));
                    checkOutput("out_valE", out_valE, out_q[0].valE);
                    checkOutput("out_valM", out_valM, out_q[0].valM);
                    checkOutput("new_pc", new_pc, out_q[0].pc);
                    checkOutput("stat", 32'(stat), 32'(out_q[0].stat));
                    if (out_ready) begin
                        void'(out_q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic applyStimulus(
        input logic [3:0]  ic,
        input logic [31:0] e,
        input logic [31:0] a,
        input logic [31:0] c,
        input logic [31:0] p,
        input logic        cnd,
        input bit          do_mem,
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input int          delay,
        input logic [31:0] rdata,
        input logic [31:0] exp_valM,
        input logic [31:0] exp_pc,
        input logic [1:0]  exp_stat,
        input int          lat
    );
        int       guard = 0;
        out_exp_t oe;
        mem_exp_t me;
        while (!in_ready && guard < 100) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_wait", 32'(in_ready), 32'h1);
            return;
        end
        ack_delay = delay;
        rdata_val = rdata;
        icode     = ic;
        valE      = e;
        valA      = a;
        valC      = c;
        valP      = p;
        Cnd       = cnd;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        valE      = 32'hFFFF_FFFF;
        valA      = 32'hFFFF_FFFF;
        valC      = 32'hFFFF_FFFF;
        valP      = 32'hFFFF_FFFF;
        oe.icode  = ic;
        oe.valE   = e;
        oe.valM   = exp_valM;
        oe.pc     = exp_pc;
        oe.stat   = exp_stat;
        oe.lat    = lat;
        oe.acc    = cyc;
        out_q.push_back(oe);
        if (do_mem) begin
            me.we    = we;
            me.addr  = addr;
            me.wdata = wdata;
            mem_q.push_back(me);
        end
    endtask

    task automatic waitDrain(input bit need_mem_empty);
        int guard = 0;
        while ((out_q.size() != 0 || (need_mem_empty && mem_q.size() != 0)) && guard < 200) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            checkOutput("drain_timeout", 32'(out_q.size()), 32'h0);
            out_q.delete();
            mem_q.delete();
            head_seen = 1'b0;
        end
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        out_q.delete();
        mem_q.delete();
        head_seen = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        icode     = 4'h0;
        valE      = 32'h0;
        valA      = 32'h0;
        valC      = 32'h0;
        valP      = 32'h0;
        Cnd       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_mem_req", 32'(bus.mem_req), 32'h0);
        checkOutput("rst_stat", 32'(stat), 32'h0);
        checkOutput("rst_new_pc", new_pc, 32'h0);
        checkOutput("rst_valM", out_valM, 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // mrmovl, slow ack: address must stay put for every waiting cycle
        applyStimulus(4'h5, 32'h100, 32'h55, 32'h7, 32'h10, 1'b0,
                      1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF,
                      32'hDEAD_BEEF, 32'h10, 2'd0, 5);
        waitDrain(1'b1);

        // call, zero-wait ack
        applyStimulus(4'h8, 32'h1FC, 32'h99, 32'h400, 32'h20, 1'b0,
                      1'b1, 1'b1, 32'h1FC, 32'h20, 0, 32'h0,
                      32'h0, 32'h400, 2'd0, 2);
        waitDrain(1'b1);

        // jXX not taken, then taken with writeback stalled for 5 cycles
        applyStimulus(4'h7, 32'h0, 32'h0, 32'h80, 32'h30, 1'b0,
                      1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0, 32'h30, 2'd0, 1);
        waitDrain(1'b1);
        out_ready = 1'b0;
        applyStimulus(4'h7, 32'h0, 32'h0, 32'h80, 32'h30, 1'b1,
                      1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0, 32'h80, 2'd0, 1);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("stall_in_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        waitDrain(1'b1);

        // rmmovl, pushl, popl, irmovl
        applyStimulus(4'h4, 32'h200, 32'h1234, 32'h8, 32'h36, 1'b0,
                      1'b1, 1'b1, 32'h200, 32'h1234, 1, 32'h0,
                      32'h0, 32'h36, 2'd0, 3);
        waitDrain(1'b1);
        applyStimulus(4'hA, 32'h1F8, 32'hCAFE, 32'h0, 32'h38, 1'b0,
                      1'b1, 1'b1, 32'h1F8, 32'hCAFE, 2, 32'h0,
                      32'h0, 32'h38, 2'd0, 4);
        waitDrain(1'b1);
        applyStimulus(4'hB, 32'h1FC, 32'h1F8, 32'h0, 32'h3A, 1'b0,
                      1'b1, 1'b0, 32'h1F8, 32'h0, 0, 32'hCAFE,
                      32'hCAFE, 32'h3A, 2'd0, 2);
        waitDrain(1'b1);
        applyStimulus(4'h3, 32'h77, 32'h0, 32'h77, 32'h40, 1'b0,
                      1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0, 32'h40, 2'd0, 1);
        waitDrain(1'b1);

        // ret reads the return address through valA
        applyStimulus(4'h9, 32'h200, 32'h1FC, 32'h0, 32'h42, 1'b0,
                      1'b1, 1'b0, 32'h1FC, 32'h0, 1, 32'h44,
                      32'h44, 32'h44, 2'd0, 3);
        waitDrain(1'b1);

        // reset while an mrmovl is waiting for its ack
        applyStimulus(4'h5, 32'h300, 32'h0, 32'h0, 32'h48, 1'b0,
                      1'b1, 1'b0, 32'h300, 32'h0, -1, 32'h0,
                      32'h0, 32'h48, 2'd0, 0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("pend_mem_req", 32'(bus.mem_req), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_req", 32'(bus.mem_req), 32'h0);
        out_q.delete();
        mem_q.delete();
        head_seen = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("post_rst_stat", 32'(stat), 32'h0);
        @(posedge clock);
        #1;

        // halt stops the pipe; a new instruction offered in STOP is ignored
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h50, 1'b0,
                      1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0, 32'h50, 2'd1, 1);
        waitDrain(1'b1);
        icode    = 4'h3;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("stop_in_ready", 32'(in_ready), 32'h0);
            checkOutput("stop_out_valid", 32'(out_valid), 32'h0);
            checkOutput("stop_stat", 32'(stat), 32'h1);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;

        // invalid icode
        pulseReset();
        applyStimulus(4'hC, 32'h0, 32'h0, 32'h0, 32'h60, 1'b0,
                      1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0, 32'h60, 2'd2, 1);
        waitDrain(1'b1);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("ins_in_ready", 32'(in_ready), 32'h0);
        checkOutput("ins_stat", 32'(stat), 32'h2);

`ifdef MEM_TIMEOUT_EN
        // ack arriving on the terminal count still completes normally
        pulseReset();
        applyStimulus(4'hA, 32'h1F4, 32'h22, 32'h0, 32'h68, 1'b0,
                      1'b1, 1'b1, 32'h1F4, 32'h22, TB_TIMEOUT - 1, 32'h0,
                      32'h0, 32'h68, 2'd0, TB_TIMEOUT + 1);
        waitDrain(1'b1);

        // pushl never acked: abort after TB_TIMEOUT request cycles
        applyStimulus(4'hA, 32'h1F0, 32'h11, 32'h0, 32'h70, 1'b0,
                      1'b1, 1'b1, 32'h1F0, 32'h11, -1, 32'h0,
                      32'h0, 32'h70, 2'd3, TB_TIMEOUT + 1);
        waitDrain(1'b0);
        mem_q.delete();
        checkOutput("tmo_req_len", last_req_len, TB_TIMEOUT);
        checkOutput("tmo_mem_req", 32'(bus.mem_req), 32'h0);
        checkOutput("tmo_in_ready", 32'(in_ready), 32'h0);
        checkOutput("tmo_stat", 32'(stat), 32'h3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/y86_memory_stage.md
# y86_memory_stage

Memory stage of the Y86 processor, sitting between execute and writeback. Accepts one instruction at a time from execute (icode, valE, valA, valC, valP, Cnd), performs at most one 32-bit data-memory read or write over a req/ack bus, and hands valM, valE and the next PC to writeback. Also detects halt and invalid instructions and stops the pipe.

## Interface
Parameters:
- DATA_W, 32, data/address width
- TIMEOUT_CYCLES, 255, cycles to wait for mem_ack before abort (MEM_TIMEOUT_EN only)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage can accept; high only in IDLE and not stopped
- icode  in  4  instruction code
- valE, valA, valC, valP  in  32 each  execute/decode/fetch values
- Cnd  in  1  branch condition from execute
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  byte address
- mem_wdata  out  32  write data
- mem_ack  in  1  request done this cycle; mem_rdata valid when read
- mem_rdata  in  32  read data
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback takes result
- out_icode  out  4; out_valE, out_valM, new_pc  out  32 each
- stat  out  2  0 AOK, 1 HLT, 2 INS (invalid icode), 3 ADR (memory timeout)

## Operation
- States: IDLE, REQ, DONE, STOP. Reset -> IDLE; all outputs 0, in_ready 1.
- IDLE: in_ready=1. On in_valid, capture all inputs; if icode is a memory op go REQ, else DONE.
- Memory ops: 4 rmmovl write valA @valE; 5 mrmovl read @valE; 8 call write valP @valE; A pushl write valA @valE; 9 ret read @valA; B popl read @valA.
- REQ: mem_req=1; mem_we/addr/wdata held constant until ack. On mem_ack sampled high, capture mem_rdata into valM for reads, -> DONE. mem_ack outside REQ ignored.
- Non-memory ops: out_valM=0.
- new_pc: call -> valC; jXX (7) with Cnd=1 -> valC; ret -> valM; otherwise valP.
- icode 0 (halt): stat=HLT. icode > B: stat=INS. Both go to DONE with no memory access; new_pc=valP.
- DONE: out_valid=1, outputs stable. On out_ready: stat AOK -> IDLE; stat non-AOK -> STOP.
- STOP: in_ready=0, out_valid=0, stat holds; left only by reset.
- Addresses not checked for alignment; passed through unchanged.

## Timing
- Accept at edge E0. Non-memory: out_valid high in cycle after E0 (latency 1).
- Memory: mem_req high in cycle after E0; ack sampled at edge Ek -> out_valid high the cycle after Ek. Zero-wait ack gives latency 2.
- Result taken at the edge where out_valid && out_ready; in_ready rises next cycle (no same-cycle accept in DONE, max throughput 1 per 2 cycles).
- out_ready held low: DONE persists, outputs frozen.
- Reset asserted mid-REQ: mem_req drops asynchronously, transaction abandoned; memory must tolerate abandoned requests.

## Configuration
- MEM_TIMEOUT_EN defined: counter starts at 0 on REQ entry, increments each REQ cycle without ack; on reaching TIMEOUT_CYCLES with no ack, drop mem_req, stat=ADR, valM=0, go DONE (then STOP). Ack in the same cycle as terminal count wins.
- Undefined: no counter; REQ waits indefinitely; stat never ADR.

## Test plan
- Reset mid-REQ with mrmovl pending -> mem_req 0 immediately, in_ready 1 after release, stat 0.
- mrmovl valE=0x100, mem_rdata=0xDEADBEEF, ack after 3 cycles -> mem_we 0, mem_addr 0x100 stable 3 cycles, out_valM 0xDEADBEEF, new_pc=valP.
- call valE=0x1FC, valP=0x20, valC=0x400, zero-wait ack -> write 0x20 to 0x1FC, new_pc 0x400, out_valid 2 cycles after accept.
- jXX Cnd=0 valP=0x30 valC=0x80 -> no mem_req, new_pc 0x30; repeat Cnd=1 -> 0x80; out_ready held low 5 cycles -> outputs frozen.
- ret valA=0x1FC, rdata 0x44 -> read @0x1FC, new_pc 0x44; then halt -> stat 1, in_ready stays 0 thereafter.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, pushl never acked -> mem_req drops after 4 cycles, stat 3, STOP.
